// File: rtl/i2c_rd_sched.sv
// Round-robin scheduler that owns the i2c read peripheral and shares it among NREQ requesters.
// Optional build macro I2C_SCHED_POLL_EN adds a periodic auto-poll virtual requester.
module i2c_rd_sched #(
  parameter int NREQ     = 2,
  parameter int START_TO = 1023,
  parameter int XFER_TO  = 65535
`ifdef I2C_SCHED_POLL_EN
  ,
  parameter int          POLL_PER = 1000000,
  parameter logic [7:0]  POLL_DEV = 8'h91
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_i,
  input  logic [8*NREQ-1:0]   dev_i,
  output logic [NREQ-1:0]     gnt_o,
  output logic [NREQ-1:0]     done_o,
  output logic                err_o,
  output logic [15:0]         rdata_o,
  output logic                m_we_o,
  output logic [31:0]         m_addr_o,
  output logic [31:0]         m_data_o,
  input  logic [31:0]         m_data_i,
  input  logic                m_busy_i
`ifdef I2C_SCHED_POLL_EN
  ,
  output logic [15:0]         poll_data_o,
  output logic                poll_vld_o
`endif
);

`ifdef I2C_SCHED_POLL_EN
  localparam int NSLOT = NREQ + 1;
`else
  localparam int NSLOT = NREQ;
`endif
  localparam int PW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  localparam logic [31:0] ADDR_DEV = 32'h7001_0000;
  localparam logic [31:0] ADDR_CMD = 32'h7003_0000;

  // Handshake: req_i is a level held by the requester until its done_o pulse;
  // gnt_o marks the owner from arbitration until the same edge that raises done_o.
  typedef enum logic [2:0] {
    S_IDLE, S_ARB, S_SETA, S_TRIG, S_WAIT, S_CAPT, S_TOUT
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [PW-1:0]   owner_q;
  logic [31:0]     to_cnt;

  logic [NSLOT-1:0] req_all;
  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [PW:0]      arb_sum;
  logic [7:0]       win_dev;
  logic [NREQ-1:0]  win_oh;
  logic [NREQ-1:0]  owner_oh;
  logic             cap_err;
  logic [15:0]      cap_data;
  logic             unused_hi;

  assign unused_hi = &{1'b0, m_data_i[31:16]};

`ifdef I2C_SCHED_POLL_EN
  logic [31:0] poll_cnt;
  logic        poll_pend;
  logic        poll_tick;
  logic        poll_take;
  logic        owner_is_poll;

  assign req_all       = {poll_pend, req_i};
  assign poll_tick     = (poll_cnt == 32'(POLL_PER - 1));
  assign poll_take     = (state_q == S_ARB) && win_vld && (win_idx == PW'(NREQ));
  assign owner_is_poll = (owner_q == PW'(NREQ));

  // A period expiring while a poll is still pending is absorbed into it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      poll_cnt  <= 32'h0;
      poll_pend <= 1'b0;
    end else begin
      poll_cnt <= poll_tick ? 32'h0 : poll_cnt + 32'h1;
      if (poll_tick)
        poll_pend <= 1'b1;
      else if (poll_take)
        poll_pend <= 1'b0;
    end
  end
`else
  assign req_all = req_i;
`endif

  // Scan from ptr+1 upward; iterating downward lets the nearest slot overwrite.
  always_comb begin
    win_vld = 1'b0;
    win_idx = ptr_q;
    arb_sum = '0;
    for (int i = NSLOT; i >= 1; i--) begin
      arb_sum = {1'b0, ptr_q} + (PW+1)'(i);
      if (arb_sum >= (PW+1)'(NSLOT))
        arb_sum = arb_sum - (PW+1)'(NSLOT);
      if (req_all[arb_sum[PW-1:0]]) begin
        win_vld = 1'b1;
        win_idx = arb_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    win_dev = 8'h00;
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == PW'(k))
        win_dev = dev_i[8*k +: 8];
    end
`ifdef I2C_SCHED_POLL_EN
    if (win_idx == PW'(NREQ))
      win_dev = POLL_DEV;
`endif
  end

  always_comb begin
    win_oh   = '0;
    owner_oh = '0;
    for (int k = 0; k < NREQ; k++) begin
      win_oh[k]   = win_vld && (win_idx == PW'(k));
      owner_oh[k] = (owner_q == PW'(k));
    end
  end

  assign cap_err  = (state_q == S_TOUT);
  assign cap_data = cap_err ? 16'h0000 : m_data_i[15:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ptr_q    <= PW'(NREQ - 1);
      owner_q  <= '0;
      to_cnt   <= 32'h0;
      gnt_o    <= '0;
      done_o   <= '0;
      err_o    <= 1'b0;
      rdata_o  <= 16'h0000;
      m_we_o   <= 1'b0;
      m_addr_o <= 32'h0;
      m_data_o <= 32'h0;
`ifdef I2C_SCHED_POLL_EN
      poll_data_o <= 16'h0000;
      poll_vld_o  <= 1'b0;
`endif
    end else begin
      done_o <= '0;
`ifdef I2C_SCHED_POLL_EN
      poll_vld_o <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (|req_all)
            state_q <= S_ARB;
        end
        S_ARB: begin
          if (win_vld) begin
            ptr_q    <= win_idx;
            owner_q  <= win_idx;
            gnt_o    <= win_oh;
            m_we_o   <= 1'b1;
            m_addr_o <= ADDR_DEV;
            m_data_o <= {24'h0, win_dev};
            state_q  <= S_SETA;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SETA: begin
          m_we_o   <= 1'b0;
          m_addr_o <= ADDR_CMD;
          m_data_o <= 32'h0;
          to_cnt   <= 32'h0;
          state_q  <= S_TRIG;
        end
        S_TRIG: begin
          if (m_busy_i) begin
            m_addr_o <= 32'h0;
            to_cnt   <= 32'h0;
            state_q  <= S_WAIT;
          end else if (to_cnt == 32'(START_TO - 1)) begin
            m_addr_o <= 32'h0;
            state_q  <= S_TOUT;
          end else begin
            to_cnt <= to_cnt + 32'h1;
          end
        end
        S_WAIT: begin
          if (!m_busy_i) begin
            m_addr_o <= ADDR_CMD;
            state_q  <= S_CAPT;
          end else if (to_cnt == 32'(XFER_TO - 1)) begin
            state_q <= S_TOUT;
          end else begin
            to_cnt <= to_cnt + 32'h1;
          end
        end
        S_CAPT, S_TOUT: begin
          m_addr_o <= 32'h0;
          gnt_o    <= '0;
          err_o    <= cap_err;
          state_q  <= S_IDLE;
`ifdef I2C_SCHED_POLL_EN
          if (owner_is_poll) begin
            poll_data_o <= cap_data;
            poll_vld_o  <= 1'b1;
          end else begin
            rdata_o <= cap_data;
            done_o  <= owner_oh;
          end
`else
          rdata_o <= cap_data;
          done_o  <= owner_oh;
`endif
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_rd_sched.sv
// Directed bench for i2c_rd_sched with a behavioural i2c busy/data model.
// Define I2C_SCHED_POLL_EN to also exercise the auto-poll requester.
module tb_i2c_rd_sched;
  localparam int NREQ     = 2;
  localparam int START_TO = 30;
  localparam int XFER_TO  = 400;
  localparam int POLL_PER = 5000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_i = 2'b00;
  logic [15:0] dev_i = 16'h0000;
  logic [1:0]  gnt_o, done_o;
  logic        err_o;
  logic [15:0] rdata_o;
  logic        m_we_o;
  logic [31:0] m_addr_o, m_data_o;
  logic [31:0] m_data_i = 32'h0;
  logic        m_busy_i = 1'b0;
`ifdef I2C_SCHED_POLL_EN
  logic [15:0] poll_data_o;
  logic        poll_vld_o;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  i2c_rd_sched #(
    .NREQ(NREQ), .START_TO(START_TO), .XFER_TO(XFER_TO)
`ifdef I2C_SCHED_POLL_EN
    , .POLL_PER(POLL_PER), .POLL_DEV(8'h91)
`endif
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .dev_i(dev_i),
    .gnt_o(gnt_o), .done_o(done_o), .err_o(err_o), .rdata_o(rdata_o),
    .m_we_o(m_we_o), .m_addr_o(m_addr_o), .m_data_o(m_data_o),
    .m_data_i(m_data_i), .m_busy_i(m_busy_i)
`ifdef I2C_SCHED_POLL_EN
    , .poll_data_o(poll_data_o), .poll_vld_o(poll_vld_o)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // i2c model: arms on the device-address write, starts busy on the trigger read
  int         mdl_len = 10;
  bit         mdl_never = 1'b0;
  bit         mdl_stuck = 1'b0;
  bit         mdl_armed = 1'b0;
  bit         mdl_active = 1'b0;
  int         mdl_cnt = 0;
  logic [7:0] last_dev = 8'h00;
  int         fall_cyc = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_busy_i   = 1'b0;
      mdl_armed  = 1'b0;
      mdl_active = 1'b0;
    end else if (m_we_o && m_addr_o == 32'h7001_0000) begin
      last_dev  = m_data_o[7:0];
      mdl_armed = 1'b1;
    end else if (mdl_armed && !m_we_o && m_addr_o == 32'h7003_0000) begin
      mdl_armed = 1'b0;
      if (!mdl_never && !mdl_active) begin
        mdl_active = 1'b1;
        mdl_cnt    = mdl_len;
        m_busy_i   = 1'b1;
      end
    end else if (mdl_active && !mdl_stuck) begin
      if (mdl_cnt > 1) mdl_cnt--;
      else begin
        mdl_active = 1'b0;
        m_busy_i   = 1'b0;
        fall_cyc   = cyc;
      end
    end
  end

  // driver: step until a done pulse or the budget expires, recording the grant seen
  task automatic run_xfer(input int budget, output logic [1:0] done_seen,
                          output logic [1:0] gnt_seen, output bit gnt_stable, output int lat);
    done_seen = 2'b00; gnt_seen = 2'b00; gnt_stable = 1'b1; lat = -1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (gnt_o != 2'b00) begin
        if (gnt_seen == 2'b00) gnt_seen = gnt_o;
        else if (gnt_o != gnt_seen) gnt_stable = 1'b0;
      end
      if (done_o != 2'b00) begin
        done_seen = done_o;
        lat = n;
        break;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_i = 2'b00;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL rst_gnt got=%h exp=0", gnt_o); end
    checks++; if (done_o !== 2'b00) begin failures++; $display("FAIL rst_done got=%h exp=0", done_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL rst_err got=%b exp=0", err_o); end
    checks++; if (rdata_o !== 16'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", rdata_o); end
    checks++; if (m_we_o !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", m_we_o); end
    checks++; if (m_addr_o !== 32'h0) begin failures++; $display("FAIL rst_addr got=%h exp=0", m_addr_o); end
    checks++; if (m_data_o !== 32'h0) begin failures++; $display("FAIL rst_mdata got=%h exp=0", m_data_o); end
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [1:0] d, g; bit st; int lat;
    dev_i = 16'h4891; mdl_len = 200; m_data_i = 32'h0000_1A2B;
    req_i = 2'b01;
    run_xfer(1000, d, g, st, lat);
    req_i = 2'b00;
    checks++; if (d !== 2'b01) begin failures++; $display("FAIL single_done got=%h exp=01", d); end
    checks++; if (g !== 2'b01) begin failures++; $display("FAIL single_gnt got=%h exp=01", g); end
    checks++; if (st !== 1'b1) begin failures++; $display("FAIL single_gnt_stable got=%b exp=1", st); end
    checks++; if (last_dev !== 8'h91) begin failures++; $display("FAIL single_seta_dev got=%h exp=91", last_dev); end
    checks++; if (cyc - fall_cyc !== 2) begin failures++; $display("FAIL single_fall_to_done got=%0d exp=2", cyc - fall_cyc); end
    checks++; if (rdata_o !== 16'h1A2B) begin failures++; $display("FAIL single_rdata got=%h exp=1a2b", rdata_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL single_err got=%b exp=0", err_o); end
    @(posedge clk); #1;
    checks++; if (done_o !== 2'b00) begin failures++; $display("FAIL single_done_pulse got=%h exp=0", done_o); end
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL single_gnt_clear got=%h exp=0", gnt_o); end
  endtask

  task automatic test_round_robin();
    logic [1:0] d, g, exp_o; bit st; int lat;
    logic [7:0] exp_dev; logic [15:0] exp_data;
    apply_reset();
    dev_i = 16'h4891; mdl_len = 10;
    req_i = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_data = 16'h1000 + 16'(t);
      m_data_i = {16'h0, exp_data};
      exp_o   = (t % 2 == 0) ? 2'b01 : 2'b10;
      exp_dev = (t % 2 == 0) ? 8'h91 : 8'h48;
      run_xfer(200, d, g, st, lat);
      checks++; if (d !== exp_o) begin failures++; $display("FAIL rr_done[%0d] got=%h exp=%h", t, d, exp_o); end
      checks++; if (g !== exp_o) begin failures++; $display("FAIL rr_gnt[%0d] got=%h exp=%h", t, g, exp_o); end
      checks++; if (last_dev !== exp_dev) begin failures++; $display("FAIL rr_dev[%0d] got=%h exp=%h", t, last_dev, exp_dev); end
      checks++; if (rdata_o !== exp_data) begin failures++; $display("FAIL rr_rdata[%0d] got=%h exp=%h", t, rdata_o, exp_data); end
    end
    req_i = 2'b00;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_start_timeout();
    logic [1:0] d, g; bit st; int lat;
    mdl_never = 1'b1;
    #1 req_i = 2'b01;
    @(posedge clk); #1;
    req_i = 2'b01;
    run_xfer(200, d, g, st, lat);
    req_i = 2'b00; mdl_never = 1'b0;
    checks++; if (d !== 2'b01) begin failures++; $display("FAIL start_to_done got=%h exp=01", d); end
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL start_to_err got=%b exp=1", err_o); end
    checks++; if (rdata_o !== 16'h0) begin failures++; $display("FAIL start_to_rdata got=%h exp=0", rdata_o); end
    checks++; if (lat !== START_TO + 3) begin failures++; $display("FAIL start_to_latency got=%0d exp=%0d", lat, START_TO + 3); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_xfer_timeout();
    logic [1:0] d, g; bit st; int lat;
    mdl_stuck = 1'b1; mdl_len = 10; m_data_i = 32'h0000_BEEF;
    @(posedge clk); #1;
    req_i = 2'b01;
    run_xfer(1000, d, g, st, lat);
    req_i = 2'b00;
    checks++; if (d !== 2'b01) begin failures++; $display("FAIL xfer_to_done got=%h exp=01", d); end
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL xfer_to_err got=%b exp=1", err_o); end
    checks++; if (rdata_o !== 16'h0) begin failures++; $display("FAIL xfer_to_rdata got=%h exp=0", rdata_o); end
    checks++; if (lat !== XFER_TO + 5) begin failures++; $display("FAIL xfer_to_latency got=%0d exp=%0d", lat, XFER_TO + 5); end
    mdl_stuck = 1'b0;
    repeat (30) @(posedge clk);
    #1 m_data_i = 32'h0000_C0DE;
    req_i = 2'b01;
    run_xfer(300, d, g, st, lat);
    req_i = 2'b00;
    checks++; if (d !== 2'b01) begin failures++; $display("FAIL xfer_after_done got=%h exp=01", d); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL xfer_after_err got=%b exp=0", err_o); end
    checks++; if (rdata_o !== 16'hC0DE) begin failures++; $display("FAIL xfer_after_rdata got=%h exp=c0de", rdata_o); end
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset_mid();
    logic [1:0] d, g; bit st; int lat; int pulses;
    mdl_len = 200;
    #1 req_i = 2'b01;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (gnt_o !== 2'b01) begin failures++; $display("FAIL mid_gnt_before got=%h exp=01", gnt_o); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (gnt_o !== 2'b00) begin failures++; $display("FAIL mid_gnt got=%h exp=0", gnt_o); end
    checks++; if (done_o !== 2'b00) begin failures++; $display("FAIL mid_done got=%h exp=0", done_o); end
    checks++; if (rdata_o !== 16'h0) begin failures++; $display("FAIL mid_rdata got=%h exp=0", rdata_o); end
    checks++; if (m_addr_o !== 32'h0) begin failures++; $display("FAIL mid_addr got=%h exp=0", m_addr_o); end
    checks++; if (m_we_o !== 1'b0) begin failures++; $display("FAIL mid_we got=%b exp=0", m_we_o); end
    req_i = 2'b00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (done_o != 2'b00) pulses++;
    end
    checks++; if (pulses !== 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", pulses); end
    mdl_len = 20; m_data_i = 32'h0000_7E57;
    req_i = 2'b01;
    run_xfer(300, d, g, st, lat);
    req_i = 2'b00;
    checks++; if (d !== 2'b01) begin failures++; $display("FAIL mid_fresh_done got=%h exp=01", d); end
    checks++; if (rdata_o !== 16'h7E57) begin failures++; $display("FAIL mid_fresh_rdata got=%h exp=7e57", rdata_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL mid_fresh_err got=%b exp=0", err_o); end
    repeat (3) @(posedge clk);
  endtask

`ifdef I2C_SCHED_POLL_EN
  task automatic test_poll();
    int polls; int dones; int t0; int t1;
    apply_reset();
    dev_i = 16'h4822; mdl_len = 10; m_data_i = 32'h0000_0B0B;
    req_i = 2'b01;
    polls = 0; dones = 0; t0 = 0; t1 = 0;
    for (int n = 0; n < 10800 && polls < 2; n++) begin
      @(posedge clk); #1;
      if (done_o != 2'b00) dones++;
      if (poll_vld_o) begin
        checks++; if (poll_data_o !== 16'h0B0B) begin failures++; $display("FAIL poll_data got=%h exp=0b0b", poll_data_o); end
        checks++; if (last_dev !== 8'h91) begin failures++; $display("FAIL poll_dev got=%h exp=91", last_dev); end
        checks++; if (done_o !== 2'b00) begin failures++; $display("FAIL poll_no_done got=%h exp=0", done_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL poll_err got=%b exp=0", err_o); end
        if (polls == 0) t0 = cyc; else t1 = cyc;
        polls++;
      end
    end
    req_i = 2'b00;
    checks++; if (polls !== 2) begin failures++; $display("FAIL poll_count got=%0d exp=2", polls); end
    checks++; if (t1 - t0 < POLL_PER - 60 || t1 - t0 > POLL_PER + 60) begin
      failures++; $display("FAIL poll_period got=%0d exp=%0d+-60", t1 - t0, POLL_PER);
    end
    checks++; if (dones < 100) begin failures++; $display("FAIL poll_interleave got=%0d exp>=100", dones); end
    repeat (3) @(posedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_start_timeout();
    test_xfer_timeout();
    test_reset_mid();
`ifdef I2C_SCHED_POLL_EN
    test_poll();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
